// File: rtl/char_ram_write_arbiter_if.sv
// Write-request and RAM write-port bundle shared by the spawner, eraser and arbiter.
interface char_ram_write_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
);
  logic              clear_req;
  logic              erase_req;
  logic [ADDR_W-1:0] erase_addr;
  logic              erase_ack;
  logic              spawn_req;
  logic [6:0]        spawn_col;
  logic [4:0]        spawn_row;
  logic [DATA_W-1:0] spawn_char;
  logic              spawn_ack;
  logic              drop;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wren;
  logic              busy;
  logic [7:0]        hit_count;

  modport master (
    output clear_req, erase_req, erase_addr, spawn_req, spawn_col, spawn_row, spawn_char,
    input  erase_ack, spawn_ack, drop, ram_waddr, ram_wdata, ram_wren, busy, hit_count
  );

  modport slave (
    input  clear_req, erase_req, erase_addr, spawn_req, spawn_col, spawn_row, spawn_char,
    output erase_ack, spawn_ack, drop, ram_waddr, ram_wdata, ram_wren, busy, hit_count
  );
endinterface

// File: rtl/char_ram_write_arbiter.sv
// Single write-port owner for the character RAM: clear sweep, round-robin
// spawn/erase arbitration, and the hit score.
module char_ram_write_arbiter #(
  parameter int unsigned COLS   = 70,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  char_ram_write_arbiter_if.slave bus
);

  localparam int unsigned CELLS = COLS * ROWS;

  typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              last_spawn_q, last_spawn_d;
  logic              erase_ack_q, erase_ack_d;
  logic              spawn_ack_q, spawn_ack_d;
  logic              drop_q, drop_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic [7:0]        hit_q, hit_d;

  logic              erase_elig, spawn_elig;
  logic              grant_erase, grant_spawn;
  logic              erase_ok, spawn_ok;
  logic [ADDR_W-1:0] spawn_addr;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      sweep_q      <= '0;
      last_spawn_q <= 1'b1;
      erase_ack_q  <= 1'b0;
      spawn_ack_q  <= 1'b0;
      drop_q       <= 1'b0;
      wren_q       <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b1;
      hit_q        <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      last_spawn_q <= last_spawn_d;
      erase_ack_q  <= erase_ack_d;
      spawn_ack_q  <= spawn_ack_d;
      drop_q       <= drop_d;
      wren_q       <= wren_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      hit_q        <= hit_d;
    end
  end

  // Next state, arbitration and write selection
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    last_spawn_d = last_spawn_q;
    erase_ack_d  = 1'b0;
    spawn_ack_d  = 1'b0;
    drop_d       = 1'b0;
    wren_d       = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    hit_d        = hit_q;
    busy_d       = (state_q == ST_CLEAR);

    // A requester whose ack is currently high is dropping its req; skip it.
    erase_elig  = bus.erase_req && !erase_ack_q;
    spawn_elig  = bus.spawn_req && !spawn_ack_q;
    grant_erase = erase_elig && (!spawn_elig || last_spawn_q);
    grant_spawn = spawn_elig && !grant_erase;
    erase_ok    = 32'(bus.erase_addr) < CELLS;
    spawn_ok    = (32'(bus.spawn_col) < COLS) && (32'(bus.spawn_row) < ROWS);
    spawn_addr  = ADDR_W'(bus.spawn_row) * ADDR_W'(COLS) + ADDR_W'(bus.spawn_col);

    if (bus.clear_req) begin
      state_d      = ST_CLEAR;
      sweep_d      = '0;
      hit_d        = '0;
      last_spawn_d = 1'b1;
      busy_d       = 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          wren_d  = 1'b1;
          waddr_d = sweep_q;
          wdata_d = '0;
          if (sweep_q == ADDR_W'(CELLS - 1)) begin
            state_d = ST_SERVE;
            sweep_d = '0;
          end else begin
            sweep_d = sweep_q + ADDR_W'(1);
          end
        end
        ST_SERVE: begin
          if (grant_erase) begin
            erase_ack_d  = 1'b1;
            last_spawn_d = 1'b0;
            if (erase_ok) begin
              wren_d  = 1'b1;
              waddr_d = bus.erase_addr;
              wdata_d = '0;
              hit_d   = hit_q + 8'd1;
            end else begin
              drop_d = 1'b1;
            end
          end else if (grant_spawn) begin
            spawn_ack_d  = 1'b1;
            last_spawn_d = 1'b1;
            if (spawn_ok) begin
              wren_d  = 1'b1;
              waddr_d = spawn_addr;
              wdata_d = bus.spawn_char;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  assign bus.erase_ack = erase_ack_q;
  assign bus.spawn_ack = spawn_ack_q;
  assign bus.drop      = drop_q;
  assign bus.ram_wren  = wren_q;
  assign bus.ram_waddr = waddr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.hit_count = hit_q;

endmodule
